alu_seq: RTL and testbench

//  Parametrised, registered successor to the combinational 8-bit ALU; sits between the register file and the writeback stage.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_mul_iter.sv | 54 +++++
 rtl/alu_seq.sv | 132 +++++++++++++
 tb/tb_alu_seq.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and flag bit positions.
package alu_pkg;

    localparam logic [3:0] OP_OR  = 4'h0;
    localparam logic [3:0] OP_AND = 4'h1;
    localparam logic [3:0] OP_SHL = 4'h2;
    localparam logic [3:0] OP_SHR = 4'h3;
    localparam logic [3:0] OP_CMP = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_ADD = 4'h7;
    localparam logic [3:0] OP_SUB = 4'h8;
    localparam logic [3:0] OP_INC = 4'h9;
    localparam logic [3:0] OP_DEC = 4'hA;
    localparam logic [3:0] OP_MUL = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FLAG_C    = 0;
    localparam int FLAG_GT   = 1;
    localparam int FLAG_EQ   = 2;
    localparam int FLAG_Z    = 3;
    localparam int FLAG_ERR  = 4;
    localparam int NUM_FLAGS = 5;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: start loads and handles bit 0, then one
// multiplier bit per clock; done is high for the single cycle the product is final.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            prod   <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            // Bit 0 is folded into the load so the product is ready WIDTH clocks after start.
            prod   <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier <= {1'b0, b[WIDTH-1:1]};
            cnt    <= CW'(WIDTH-1);
            busy   <= 1'b1;
        end else if (busy) begin
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                if (mplier[0]) begin
                    prod <= prod + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
            end
        end
    end

    assign done    = busy && (cnt == '0);
    assign product = prod;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides and an iterative MUL; results are
// held in output registers until the consumer takes them.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] regA,
    input  logic [WIDTH-1:0] regB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] acc_hi,
    output logic             flag_c,
    output logic             flag_gt,
    output logic             flag_eq,
    output logic             flag_z,
    output logic             flag_err
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high.
    // out_valid is held with stable data until taken; in_ready never depends on in_valid.
    state_t                 state_q, state_d;
    logic                   accept, is_mul, mul_start, mul_done;
    logic [2*WIDTH-1:0]     product;
    logic [WIDTH-1:0]       dp_res, acc_q, acc_hi_q;
    logic [WIDTH:0]         ext;
    logic [NUM_FLAGS-1:0]   dp_flags, mul_flags, flags_q;

    assign is_mul    = MUL_EN && (opcode == OP_MUL);
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && is_mul;
    assign out_valid = (state_q == ST_DONE);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (regA),
        .b       (regB),
        .done    (mul_done),
        .product (product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = is_mul ? ST_BUSY : ST_DONE;
            ST_BUSY: if (mul_done) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = accept ? (is_mul ? ST_BUSY : ST_DONE) : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Single-cycle datapath; MUL lands in the default arm, used only when MUL is not built.
    always_comb begin
        dp_res   = '0;
        dp_flags = '0;
        ext      = '0;
        case (opcode)
            OP_OR:  dp_res = regA | regB;
            OP_AND: dp_res = regA & regB;
            OP_SHL: dp_res = {regA[WIDTH-2:0], 1'b0};
            OP_SHR: dp_res = {1'b0, regA[WIDTH-1:1]};
            OP_CMP: begin
                dp_flags[FLAG_GT] = regA > regB;
                dp_flags[FLAG_EQ] = regA == regB;
            end
            OP_NOT: dp_res = ~regA;
            OP_XOR: dp_res = regA ^ regB;
            OP_ADD: ext = {1'b0, regA} + {1'b0, regB};
            OP_SUB: ext = {1'b0, regA} - {1'b0, regB};
            OP_INC: ext = {1'b0, regA} + (WIDTH+1)'(1);
            OP_DEC: ext = {1'b0, regA} - (WIDTH+1)'(1);
            default: dp_flags[FLAG_ERR] = 1'b1;
        endcase
        if (opcode inside {OP_ADD, OP_SUB, OP_INC, OP_DEC}) begin
            dp_res           = ext[WIDTH-1:0];
            dp_flags[FLAG_C] = ext[WIDTH];
        end
        if (opcode == OP_CMP) begin
            dp_flags[FLAG_Z] = dp_flags[FLAG_EQ];
        end else if (!dp_flags[FLAG_ERR]) begin
            dp_flags[FLAG_Z] = (dp_res == '0);
        end
    end

    always_comb begin
        mul_flags         = '0;
        mul_flags[FLAG_Z] = (product == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            acc_hi_q <= '0;
            flags_q  <= '0;
        end else if (accept && !is_mul) begin
            acc_q    <= dp_res;
            acc_hi_q <= '0;
            flags_q  <= dp_flags;
        end else if (mul_done) begin
            acc_q    <= product[WIDTH-1:0];
            acc_hi_q <= product[2*WIDTH-1:WIDTH];
            flags_q  <= mul_flags;
        end
    end

    assign acc      = acc_q;
    assign acc_hi   = acc_hi_q;
    assign flag_c   = flags_q[FLAG_C];
    assign flag_gt  = flags_q[FLAG_GT];
    assign flag_eq  = flags_q[FLAG_EQ];
    assign flag_z   = flags_q[FLAG_Z];
    assign flag_err = flags_q[FLAG_ERR];

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: reset checks, a vector table, hand-written handshake/MUL/reset
// sequences, and randomized traffic scored against an arithmetic reference model.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] acc;
        logic [W-1:0] hi;
        logic         c;
        logic         gt;
        logic         eq;
        logic         z;
        logic         err;
    } res_t;
    localparam int RES_W = $bits(res_t);

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        res_t         exp;
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0, out_ready = 1'b1;
    logic [3:0]   opcode = '0;
    logic [W-1:0] regA = '0, regB = '0;
    logic         in_ready, out_valid, flag_c, flag_gt, flag_eq, flag_z, flag_err;
    logic [W-1:0] acc, acc_hi;
    logic         in_ready0, out_valid0, flag_c0, flag_gt0, flag_eq0, flag_z0, flag_err0;
    logic [W-1:0] acc0, acc_hi0;

    alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .regA(regA), .regB(regB), .out_valid(out_valid),
        .out_ready(out_ready), .acc(acc), .acc_hi(acc_hi), .flag_c(flag_c),
        .flag_gt(flag_gt), .flag_eq(flag_eq), .flag_z(flag_z), .flag_err(flag_err)
    );

    alu_seq #(.WIDTH(W), .MUL_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .opcode(opcode), .regA(regA), .regB(regB), .out_valid(out_valid0),
        .out_ready(out_ready), .acc(acc0), .acc_hi(acc_hi0), .flag_c(flag_c0),
        .flag_gt(flag_gt0), .flag_eq(flag_eq0), .flag_z(flag_z0), .flag_err(flag_err0)
    );

    int total = 0;
    int bad = 0;
    logic [RES_W-1:0] exp_q[$];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic res_t mk(input logic [W-1:0] a, input logic [W-1:0] h,
                                input logic c, input logic gt, input logic eq,
                                input logic z, input logic err);
        mk = {a, h, c, gt, eq, z, err};
    endfunction

    function automatic res_t act();
        act = {acc, acc_hi, flag_c, flag_gt, flag_eq, flag_z, flag_err};
    endfunction

    function automatic res_t act0();
        act0 = {acc0, acc_hi0, flag_c0, flag_gt0, flag_eq0, flag_z0, flag_err0};
    endfunction

    // reference model: plain integer arithmetic on the opcode table
    function automatic res_t ref_alu(input logic [3:0] op, input int a, input int b);
        res_t x = '0;
        int r = 0;
        int p;
        case (op)
            4'h0: r = a | b;
            4'h1: r = a & b;
            4'h2: r = (a * 2) % 256;
            4'h3: r = a / 2;
            4'h4: begin x.gt = a > b; x.eq = a == b; end
            4'h5: r = 255 - a;
            4'h6: r = a ^ b;
            4'h7: begin r = a + b; x.c = r > 255; r = r % 256; end
            4'h8: begin x.c = a < b; r = (a - b + 256) % 256; end
            4'h9: begin r = a + 1; x.c = r > 255; r = r % 256; end
            4'hA: begin x.c = a == 0; r = (a + 255) % 256; end
            4'hB: begin
                p = a * b;
                x.acc = p[7:0];
                x.hi = p[15:8];
                x.z = p == 0;
                return x;
            end
            default: begin x.err = 1'b1; return x; end
        endcase
        x.acc = r[7:0];
        x.z = (op == 4'h4) ? x.eq : (r == 0);
        return x;
    endfunction

    // scoreboard comparisons
    task automatic check_res(input string name, input res_t got, input res_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got acc=%h hi=%h c=%b gt=%b eq=%b z=%b err=%b, want acc=%h hi=%h c=%b gt=%b eq=%b z=%b err=%b",
                     name, got.acc, got.hi, got.c, got.gt, got.eq, got.z, got.err,
                     want.acc, want.hi, want.c, want.gt, want.eq, want.z, want.err);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // driver tasks
    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        opcode = op;
        regA = a;
        regB = b;
        in_valid = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // advance until out_valid, dropping in_valid after the first edge; n = edges taken
    task automatic wait_out(output int n);
        n = 0;
        do begin
            next_cycle();
            n++;
            if (n == 1) in_valid = 1'b0;
        end while (!out_valid && n < 30);
        if (!out_valid) check_val("wait_out_timeout", 0, 1);
    endtask

    vec_t vecs[17];
    int n;
    logic pend, exp_ov, exp_ir, xo, ac;
    int mul_left;
    int stale;

    initial begin
        vecs[0]  = '{OP_ADD, 8'hF0, 8'h20, mk(8'h10, 8'h00, 1, 0, 0, 0, 0)};
        vecs[1]  = '{OP_OR,  8'h0C, 8'h30, mk(8'h3C, 8'h00, 0, 0, 0, 0, 0)};
        vecs[2]  = '{OP_AND, 8'h0C, 8'h0A, mk(8'h08, 8'h00, 0, 0, 0, 0, 0)};
        vecs[3]  = '{OP_SHL, 8'h81, 8'h00, mk(8'h02, 8'h00, 0, 0, 0, 0, 0)};
        vecs[4]  = '{OP_SHR, 8'h81, 8'h00, mk(8'h40, 8'h00, 0, 0, 0, 0, 0)};
        vecs[5]  = '{OP_NOT, 8'h0F, 8'h77, mk(8'hF0, 8'h00, 0, 0, 0, 0, 0)};
        vecs[6]  = '{OP_XOR, 8'h5A, 8'h5A, mk(8'h00, 8'h00, 0, 0, 0, 1, 0)};
        vecs[7]  = '{OP_SUB, 8'h03, 8'h05, mk(8'hFE, 8'h00, 1, 0, 0, 0, 0)};
        vecs[8]  = '{OP_SUB, 8'h05, 8'h03, mk(8'h02, 8'h00, 0, 0, 0, 0, 0)};
        vecs[9]  = '{OP_INC, 8'hFF, 8'h00, mk(8'h00, 8'h00, 1, 0, 0, 1, 0)};
        vecs[10] = '{OP_DEC, 8'h00, 8'h00, mk(8'hFF, 8'h00, 1, 0, 0, 0, 0)};
        vecs[11] = '{OP_CMP, 8'h03, 8'h09, mk(8'h00, 8'h00, 0, 0, 0, 0, 0)};
        vecs[12] = '{OP_MUL, 8'h0F, 8'h11, mk(8'hFF, 8'h00, 0, 0, 0, 0, 0)};
        vecs[13] = '{4'hE,   8'h12, 8'h34, mk(8'h00, 8'h00, 0, 0, 0, 0, 1)};
        vecs[14] = '{OP_MUL, 8'h00, 8'h37, mk(8'h00, 8'h00, 0, 0, 0, 1, 0)};
        vecs[15] = '{OP_ADD, 8'h80, 8'h80, mk(8'h00, 8'h00, 1, 0, 0, 1, 0)};
        vecs[16] = '{4'hC,   8'hFF, 8'hFF, mk(8'h00, 8'h00, 0, 0, 0, 0, 1)};

        // reset state, during and after reset
        repeat (3) @(negedge clk);
        check_val("rst_out_valid", int'(out_valid), 0);
        check_res("rst_outputs", act(), '0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_in_ready", int'(in_ready), 1);
        check_val("post_rst_out_valid", int'(out_valid), 0);
        check_res("post_rst_outputs", act(), '0);

        // MUL with MUL_EN=0 is illegal and single-cycle; the MUL_EN=1 copy runs it properly
        drive(OP_MUL, 8'h03, 8'h04);
        next_cycle();
        in_valid = 1'b0;
        check_val("mul_dis_out_valid", int'(out_valid0), 1);
        check_res("mul_dis_err", act0(), mk(8'h00, 8'h00, 0, 0, 0, 0, 1));
        check_val("mul_en_busy", int'(in_ready), 0);
        n = 1;
        while (!out_valid && n < 30) begin
            next_cycle();
            n++;
        end
        check_val("mul_en_latency", n, W + 1);
        check_res("mul_en_result", act(), mk(8'h0C, 8'h00, 0, 0, 0, 0, 0));

        // vector table, out_ready held high
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            #1;
            check_val($sformatf("vec%0d_in_ready", i), int'(in_ready), 1);
            wait_out(n);
            check_val($sformatf("vec%0d_latency", i), n, (vecs[i].op == OP_MUL) ? W + 1 : 1);
            check_res($sformatf("vec%0d_result", i), act(), vecs[i].exp);
        end

        // back-to-back CMP: one result per clock
        drive(OP_CMP, 8'h05, 8'h05);
        #1;
        check_val("cmp1_in_ready", int'(in_ready), 1);
        next_cycle();
        check_val("cmp1_out_valid", int'(out_valid), 1);
        check_res("cmp1_result", act(), mk(8'h00, 8'h00, 0, 0, 1, 1, 0));
        drive(OP_CMP, 8'h09, 8'h03);
        #1;
        check_val("cmp2_in_ready", int'(in_ready), 1);
        next_cycle();
        in_valid = 1'b0;
        check_val("cmp2_out_valid", int'(out_valid), 1);
        check_res("cmp2_result", act(), mk(8'h00, 8'h00, 0, 1, 0, 0, 0));
        next_cycle();
        check_val("cmp_drain_out_valid", int'(out_valid), 0);

        // MUL 0xFF*0xFF: input side stalled for W cycles; operands changed after accept
        drive(OP_MUL, 8'hFF, 8'hFF);
        next_cycle();
        in_valid = 1'b0;
        regA = 8'h00;
        regB = 8'h00;
        for (int i = 0; i < W; i++) begin
            check_val($sformatf("mul_busy%0d_in_ready", i), int'(in_ready), 0);
            check_val($sformatf("mul_busy%0d_out_valid", i), int'(out_valid), 0);
            next_cycle();
        end
        check_val("mul_ff_out_valid", int'(out_valid), 1);
        check_res("mul_ff_result", act(), mk(8'h01, 8'hFE, 0, 0, 0, 0, 0));

        // DEC 0 accepted while MUL result drains, then held with out_ready low
        drive(OP_DEC, 8'h00, 8'h55);
        #1;
        check_val("dec_in_ready", int'(in_ready), 1);
        next_cycle();
        out_ready = 1'b0;
        drive(OP_ADD, 8'h01, 8'h01);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val($sformatf("hold%0d_in_ready", i), int'(in_ready), 0);
            check_val($sformatf("hold%0d_out_valid", i), int'(out_valid), 1);
            check_res($sformatf("hold%0d_result", i), act(), mk(8'hFF, 8'h00, 1, 0, 0, 0, 0));
            next_cycle();
        end
        out_ready = 1'b1;
        #1;
        check_val("hold_release_in_ready", int'(in_ready), 1);
        next_cycle();
        in_valid = 1'b0;
        check_val("after_hold_out_valid", int'(out_valid), 1);
        check_res("after_hold_add", act(), mk(8'h02, 8'h00, 0, 0, 0, 0, 0));
        next_cycle();
        check_val("idle_out_valid", int'(out_valid), 0);
        check_res("idle_keeps_last", act(), mk(8'h02, 8'h00, 0, 0, 0, 0, 0));

        // asynchronous reset in the 4th cycle of a MUL
        drive(OP_MUL, 8'hFF, 8'hFF);
        next_cycle();
        in_valid = 1'b0;
        repeat (3) next_cycle();
        rst_n = 1'b0;
        #1;
        check_val("mid_mul_rst_out_valid", int'(out_valid), 0);
        check_res("mid_mul_rst_outputs", act(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("mid_mul_post_in_ready", int'(in_ready), 1);
        drive(OP_ADD, 8'h01, 8'h01);
        wait_out(n);
        check_val("post_rst_add_latency", n, 1);
        check_res("post_rst_add", act(), mk(8'h02, 8'h00, 0, 0, 0, 0, 0));
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            if (out_valid) stale++;
        end
        check_val("no_stale_mul_result", stale, 0);

        // randomized traffic against the reference model
        pend = 1'b0;
        mul_left = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 2500; cyc++) begin
            exp_ov = pend && (mul_left == 0);
            check_val("rnd_out_valid", int'(out_valid), int'(exp_ov));
            if (exp_ov && exp_q.size() > 0) check_res("rnd_result", act(), exp_q[0]);
            in_valid = $urandom_range(0, 99) < 70;
            opcode = 4'($urandom_range(0, 15));
            regA = 8'($urandom_range(0, 255));
            regB = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 7))
                0: regB = regA;
                1: regA = 8'h00;
                2: regA = 8'hFF;
                default: ;
            endcase
            out_ready = $urandom_range(0, 99) < 70;
            #1;
            exp_ir = !pend || ((mul_left == 0) && out_ready);
            check_val("rnd_in_ready", int'(in_ready), int'(exp_ir));
            xo = exp_ov && out_ready;
            ac = in_valid && exp_ir;
            @(posedge clk);
            if (xo) begin
                void'(exp_q.pop_front());
                pend = 1'b0;
            end
            if (ac) begin
                exp_q.push_back(ref_alu(opcode, int'(regA), int'(regB)));
                pend = 1'b1;
                mul_left = (opcode == OP_MUL) ? W : 0;
            end else if (mul_left > 0) begin
                mul_left--;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
